// File: rtl/cfg_serial_loader.sv
// Serial configuration front-end for the PLL config input.
// Collects a framed serial word (WIDTH data bits, MSB first, then one even
// parity bit) and commits the data to cfg only when the frame length and
// parity are both correct. cfg holds its last good value otherwise.
module cfg_serial_loader #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] DEFAULT = WIDTH'(1),
    parameter int               ERRW    = 4
) (
    input  logic             clkin,
    input  logic             rstn,
    input  logic             sen,
    input  logic             sdi,
    input  logic             sdi_vld,
    output logic [WIDTH-1:0] cfg,
    output logic             cfg_valid,
    output logic             cfg_update,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [ERRW-1:0]  err_cnt,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 2);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam logic [1:0] ERR_SHORT   = 2'b01;
    localparam logic [1:0] ERR_OVERRUN = 2'b10;
    localparam logic [1:0] ERR_PARITY  = 2'b11;

    // Count value just before the final (parity) bit lands.
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic [1:0]     state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [WIDTH:0] shreg, shreg_nxt;
    logic           do_commit;
    logic           do_err;
    logic [1:0]     code_nxt;

    // Next-state, shift-register and frame-verdict decode.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        do_commit = 1'b0;
        do_err    = 1'b0;
        code_nxt  = err_code;
        case (state)
            IDLE: begin
                if (sen) begin
                    state_nxt = SHIFT;
                    if (sdi_vld) begin
                        shreg_nxt = {shreg[WIDTH-1:0], sdi};
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            SHIFT: begin
                if (sen) begin
                    if (sdi_vld) begin
                        shreg_nxt = {shreg[WIDTH-1:0], sdi};
                        cnt_nxt   = cnt + 1'b1;
                        if (cnt == LAST) state_nxt = FULL;
                    end
                end else begin
                    // A bit arriving with sen low is not part of the frame.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    if (cnt != '0) begin
                        do_err   = 1'b1;
                        code_nxt = ERR_SHORT;
                    end
                end
            end
            FULL: begin
                if (sen) begin
                    if (sdi_vld) begin
                        state_nxt = DRAIN;
                        do_err    = 1'b1;
                        code_nxt  = ERR_OVERRUN;
                    end
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    if (^shreg == 1'b0) begin
                        do_commit = 1'b1;
                    end else begin
                        do_err   = 1'b1;
                        code_nxt = ERR_PARITY;
                    end
                end
            end
            default: begin // DRAIN: swallow the rest of an overrun frame
                if (!sen) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
        endcase
    end

    // Register update: reset dominates; cfg moves only on a good commit.
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clkin) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            cfg        <= DEFAULT;
            cfg_valid  <= 1'b0;
            cfg_update <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
            err_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shreg      <= shreg_nxt;
            cfg_update <= do_commit;
            err        <= do_err;
            err_code   <= code_nxt;
            if (do_commit) begin
                cfg       <= shreg[WIDTH:1];
                cfg_valid <= 1'b1;
            end
            if (do_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_cfg_serial_loader.sv
// Directed self-checking bench for cfg_serial_loader (WIDTH=8, ERRW=4).
module tb_cfg_serial_loader;

    logic       clkin = 1'b0;
    logic       rstn;
    logic       sen;
    logic       sdi;
    logic       sdi_vld;
    logic [7:0] cfg;
    logic       cfg_valid;
    logic       cfg_update;
    logic       err;
    logic [1:0] err_code;
    logic [3:0] err_cnt;
    logic       busy;

    int tests  = 0;
    int failed = 0;

    cfg_serial_loader #(.WIDTH(8), .DEFAULT(8'h01), .ERRW(4)) dut (
        .clkin      (clkin),
        .rstn       (rstn),
        .sen        (sen),
        .sdi        (sdi),
        .sdi_vld    (sdi_vld),
        .cfg        (cfg),
        .cfg_valid  (cfg_valid),
        .cfg_update (cfg_update),
        .err        (err),
        .err_code   (err_code),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    always #5 clkin = ~clkin;

    // Advance one clock; outputs are then stable 1 time unit past the edge.
    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Shift n bits of v (MSB first) with sen held high; frame is left open.
    task automatic send_bits(input logic [15:0] v, input int n);
        sen = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            sdi     = v[i];
            sdi_vld = 1'b1;
            tick();
        end
        sdi_vld = 1'b0;
        sdi     = 1'b0;
    endtask

    // Close the frame: one cycle with sen low.
    task automatic end_frame();
        sen     = 1'b0;
        sdi_vld = 1'b0;
        tick();
    endtask

    initial begin
        rstn = 1'b0; sen = 1'b0; sdi = 1'b0; sdi_vld = 1'b0;

        // 1. reset held 5 cycles
        repeat (5) tick();
        check("rst_cfg",       cfg,        32'h01);
        check("rst_cfg_valid", cfg_valid,  32'd0);
        check("rst_busy",      busy,       32'd0);
        check("rst_err_cnt",   err_cnt,    32'd0);
        check("rst_err_code",  err_code,   32'd0);
        check("rst_update",    cfg_update, 32'd0);
        rstn = 1'b1;
        tick();

        // 2. good frame 0x5A, parity 0
        send_bits({7'd0, 8'h5A, 1'b0}, 9);
        check("t2_busy_full", busy, 32'd1);
        end_frame();
        check("t2_cfg",       cfg,        32'h5A);
        check("t2_update",    cfg_update, 32'd1);
        check("t2_valid",     cfg_valid,  32'd1);
        check("t2_err",       err,        32'd0);
        check("t2_busy_idle", busy,       32'd0);
        tick();
        check("t2_update_1cy", cfg_update, 32'd0);

        // 3. 0x07 with parity 0 -> parity error
        send_bits({7'd0, 8'h07, 1'b0}, 9);
        end_frame();
        check("t3_err",      err,        32'd1);
        check("t3_code",     err_code,   32'd3);
        check("t3_cnt",      err_cnt,    32'd1);
        check("t3_cfg",      cfg,        32'h5A);
        check("t3_no_update", cfg_update, 32'd0);
        tick();
        check("t3_err_1cy",  err,        32'd0);
        check("t3_code_hold", err_code,  32'd3);

        // 4. short frame (5 bits), then an empty sen pulse
        send_bits(16'h0015, 5);
        end_frame();
        check("t4_err",  err,      32'd1);
        check("t4_code", err_code, 32'd1);
        check("t4_cnt",  err_cnt,  32'd2);
        check("t4_cfg",  cfg,      32'h5A);
        tick();
        sen = 1'b1;
        tick();
        check("t4_empty_busy", busy, 32'd1);
        end_frame();
        check("t4_empty_err", err,     32'd0);
        check("t4_empty_cnt", err_cnt, 32'd2);
        tick();
        check("t4_empty_err2", err,  32'd0);
        check("t4_empty_idle", busy, 32'd0);

        // 5. overrun: 10 bits in one frame
        send_bits({6'd0, 8'hA5, 1'b0, 1'b1}, 10);
        check("t5_err",   err,      32'd1);
        check("t5_code",  err_code, 32'd2);
        check("t5_cnt",   err_cnt,  32'd3);
        check("t5_busy",  busy,     32'd1);
        send_bits(16'h0003, 2);
        check("t5_drain_busy", busy, 32'd1);
        check("t5_drain_err",  err,  32'd0);
        end_frame();
        check("t5_idle",      busy,       32'd0);
        check("t5_no_update", cfg_update, 32'd0);
        check("t5_no_err",    err,        32'd0);
        check("t5_cfg",       cfg,        32'h5A);
        check("t5_cnt_hold",  err_cnt,    32'd3);

        // 6. reset mid-frame, then good 0xC3 frame
        send_bits(16'h000F, 4);
        sen = 1'b1;
        rstn = 1'b0;
        tick();
        check("t6_cfg_def", cfg,       32'h01);
        check("t6_idle",    busy,      32'd0);
        check("t6_valid",   cfg_valid, 32'd0);
        check("t6_errcnt",  err_cnt,   32'd0);
        check("t6_errcode", err_code,  32'd0);
        rstn = 1'b1;
        sen  = 1'b0;
        tick();
        send_bits({7'd0, 8'hC3, 1'b0}, 9);
        end_frame();
        check("t6_cfg",    cfg,        32'hC3);
        check("t6_update", cfg_update, 32'd1);
        check("t6_valid2", cfg_valid,  32'd1);
        check("t6_err",    err,        32'd0);
        tick();

        // Extra: 17 rejected frames saturate the 4-bit counter at 15
        for (int k = 1; k <= 17; k++) begin
            send_bits(16'h0001, 1);
            end_frame();
            if (k == 14) check("sat_14", err_cnt, 32'd14);
            if (k == 15) check("sat_15", err_cnt, 32'd15);
        end
        check("sat_17",      err_cnt,  32'd15);
        check("sat_err",     err,      32'd1);
        check("sat_code",    err_code, 32'd1);
        check("sat_cfg",     cfg,      32'hC3);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
